// File: rtl/rgb_to_ycbcr_mac_if.sv
// Stream bundle for rgb_to_ycbcr_mac: serial R,G,B component input and converted pixel output.
interface rgb_to_ycbcr_mac_if #(
    parameter int unsigned DATA_W = 8
);
    logic              s_valid;
    logic              s_ready;
    logic              s_first;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_y;
    logic [DATA_W-1:0] m_cb;
    logic [DATA_W-1:0] m_cr;

    modport slave (
        input  s_valid, s_first, s_data, m_ready,
        output s_ready, m_valid, m_y, m_cb, m_cr
    );

    modport master (
        output s_valid, s_first, s_data, m_ready,
        input  s_ready, m_valid, m_y, m_cb, m_cr
    );
endinterface

// File: rtl/rgb_to_ycbcr_mac.sv
// Serial RGB -> YCbCr converter: one MAC step per component beat, pixel registered after the B beat.
// Define RGB2YCC_CLAMP_EN to saturate results; otherwise results wrap to DATA_W bits.
module rgb_to_ycbcr_mac #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned FRAC_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    rgb_to_ycbcr_mac_if.slave        bus,
    output logic [1:0]               phase_o,
    output logic                     sync_err_o
);
    localparam int unsigned ACC_W = DATA_W + 10;

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef enum logic [1:0] {PH_R = 2'd0, PH_G = 2'd1, PH_B = 2'd2} phase_e;

    localparam acc_t RND_C = acc_t'(1 << (FRAC_W - 1));
    localparam acc_t OFF_C = acc_t'(1 << (DATA_W - 1));
    localparam acc_t MAX_C = acc_t'((1 << DATA_W) - 1);

    phase_e            phase, phase_nxt, eff_ph;
    acc_t              acc_y, acc_cb, acc_cr;
    acc_t              acc_y_nxt, acc_cb_nxt, acc_cr_nxt;
    acc_t              c_y, c_cb, c_cr, data_ext;
    acc_t              sum_y, sum_cb, sum_cr;
    acc_t              res_y, res_cb, res_cr;
    logic              m_valid_q, m_valid_nxt;
    logic [DATA_W-1:0] y_q, cb_q, cr_q, y_nxt, cb_nxt, cr_nxt;
    logic              sync_err_q, sync_err_nxt;
    logic              s_ready_c, accept_c;

    function automatic logic [DATA_W-1:0] fit(input acc_t v);
`ifdef RGB2YCC_CLAMP_EN
        if (v < acc_t'(0))  return '0;
        if (v > MAX_C)      return '1;
        return DATA_W'(v);
`else
        return DATA_W'(v);
`endif
    endfunction

    assign s_ready_c   = !m_valid_q || bus.m_ready;
    assign accept_c    = bus.s_valid && s_ready_c;
    // s_first forces the beat to be treated as R regardless of the tracked phase
    assign eff_ph      = bus.s_first ? PH_R : phase;
    assign data_ext    = acc_t'(bus.s_data);

    assign bus.s_ready = s_ready_c;
    assign bus.m_valid = m_valid_q;
    assign bus.m_y     = y_q;
    assign bus.m_cb    = cb_q;
    assign bus.m_cr    = cr_q;
    assign phase_o     = phase;
    assign sync_err_o  = sync_err_q;

    // Coefficient row selection and multiply-accumulate for the current beat
    always_comb begin
        c_y  = '0;
        c_cb = '0;
        c_cr = '0;
        case (eff_ph)
            PH_R:    begin c_y = acc_t'(77);  c_cb = acc_t'(-43); c_cr = acc_t'(128);  end
            PH_G:    begin c_y = acc_t'(150); c_cb = acc_t'(-85); c_cr = acc_t'(-107); end
            PH_B:    begin c_y = acc_t'(29);  c_cb = acc_t'(128); c_cr = acc_t'(-21);  end
            default: begin c_y = '0;          c_cb = '0;          c_cr = '0;           end
        endcase
        sum_y  = ((eff_ph == PH_R) ? acc_t'(0) : acc_y)  + data_ext * c_y;
        sum_cb = ((eff_ph == PH_R) ? acc_t'(0) : acc_cb) + data_ext * c_cb;
        sum_cr = ((eff_ph == PH_R) ? acc_t'(0) : acc_cr) + data_ext * c_cr;
        res_y  = (sum_y  + RND_C) >>> FRAC_W;
        res_cb = ((sum_cb + RND_C) >>> FRAC_W) + OFF_C;
        res_cr = ((sum_cr + RND_C) >>> FRAC_W) + OFF_C;
    end

    // Next-state: phase sequencing, accumulator update, output handshake
    always_comb begin
        phase_nxt    = phase;
        acc_y_nxt    = acc_y;
        acc_cb_nxt   = acc_cb;
        acc_cr_nxt   = acc_cr;
        m_valid_nxt  = m_valid_q;
        y_nxt        = y_q;
        cb_nxt       = cb_q;
        cr_nxt       = cr_q;
        sync_err_nxt = 1'b0;
        if (bus.m_ready) begin
            m_valid_nxt = 1'b0;
        end
        if (accept_c) begin
            sync_err_nxt = bus.s_first && (phase != PH_R);
            acc_y_nxt    = sum_y;
            acc_cb_nxt   = sum_cb;
            acc_cr_nxt   = sum_cr;
            case (eff_ph)
                PH_R:    phase_nxt = PH_G;
                PH_G:    phase_nxt = PH_B;
                default: phase_nxt = PH_R;
            endcase
            if (eff_ph == PH_B) begin
                m_valid_nxt = 1'b1;
                y_nxt       = fit(res_y);
                cb_nxt      = fit(res_cb);
                cr_nxt      = fit(res_cr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase      <= PH_R;
            acc_y      <= '0;
            acc_cb     <= '0;
            acc_cr     <= '0;
            m_valid_q  <= 1'b0;
            y_q        <= '0;
            cb_q       <= '0;
            cr_q       <= '0;
            sync_err_q <= 1'b0;
        end else begin
            phase      <= phase_nxt;
            acc_y      <= acc_y_nxt;
            acc_cb     <= acc_cb_nxt;
            acc_cr     <= acc_cr_nxt;
            m_valid_q  <= m_valid_nxt;
            y_q        <= y_nxt;
            cb_q       <= cb_nxt;
            cr_q       <= cr_nxt;
            sync_err_q <= sync_err_nxt;
        end
    end
endmodule

// File: tb/tb_rgb_to_ycbcr_mac.sv
// Self-checking bench for rgb_to_ycbcr_mac: directed literal cases plus randomized traffic
// compared every cycle against a pixel-level arithmetic model.
`timescale 1ns/1ps
module tb_rgb_to_ycbcr_mac;
    localparam int unsigned DATA_W = 8;
    localparam int MAXV = (1 << DATA_W) - 1;
    localparam int OFF  = 1 << (DATA_W - 1);
`ifdef RGB2YCC_CLAMP_EN
    localparam int RED_CR  = 255;
    localparam int BLUE_CB = 255;
`else
    localparam int RED_CR  = 0;
    localparam int BLUE_CB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] phase_o;
    logic       sync_err_o;

    rgb_to_ycbcr_mac_if #(.DATA_W(DATA_W)) bus ();

    rgb_to_ycbcr_mac #(.DATA_W(DATA_W), .FRAC_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .phase_o    (phase_o),
        .sync_err_o (sync_err_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int fit(input int v);
`ifdef RGB2YCC_CLAMP_EN
        if (v < 0)    return 0;
        if (v > MAXV) return MAXV;
        return v;
`else
        return v & MAXV;
`endif
    endfunction

    // Pixel-level reference: plain integer matrix product with round-half-up
    task automatic convert(input int r, input int g, input int b,
                           output int y, output int cb, output int cr);
        y  = fit((77 * r + 150 * g + 29 * b + 128) >>> 8);
        cb = fit(((-43 * r - 85 * g + 128 * b + 128) >>> 8) + OFF);
        cr = fit(((128 * r - 107 * g - 21 * b + 128) >>> 8) + OFF);
    endtask

    // Model state: components collected so far for the pixel in flight, and expected outputs
    int cnt = 0;
    int comp [3];
    bit exp_mvalid = 0;
    bit exp_err = 0;
    int exp_y = 0, exp_cb = 0, exp_cr = 0;
    bit started = 0;

    always @(posedge clk) begin : model
        bit take;
        int y, cb, cr;
        if (rst) begin
            cnt = 0; exp_mvalid = 0; exp_err = 0;
            exp_y = 0; exp_cb = 0; exp_cr = 0;
            started = 1;
        end else begin
            take = bus.s_valid && (!exp_mvalid || bus.m_ready);
            exp_err = 0;
            if (bus.m_ready) exp_mvalid = 0;
            if (take) begin
                if (bus.s_first) begin
                    if (cnt != 0) exp_err = 1;
                    cnt = 0;
                end
                comp[cnt] = int'(bus.s_data);
                if (cnt == 2) begin
                    convert(comp[0], comp[1], comp[2], y, cb, cr);
                    exp_y = y; exp_cb = cb; exp_cr = cr;
                    exp_mvalid = 1;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    // Every-cycle comparison against the model, sampled mid-cycle
    always @(negedge clk) begin
        if (started) begin
            chk("s_ready",    int'(bus.s_ready), int'(!exp_mvalid || bus.m_ready));
            chk("m_valid",    int'(bus.m_valid), int'(exp_mvalid));
            chk("m_y",        int'(bus.m_y),     exp_y);
            chk("m_cb",       int'(bus.m_cb),    exp_cb);
            chk("m_cr",       int'(bus.m_cr),    exp_cr);
            chk("phase_o",    int'(phase_o),     cnt);
            chk("sync_err_o", int'(sync_err_o),  int'(exp_err));
        end
    end

    task automatic send_beat(input bit first, input int data);
        bit took;
        took = 0;
        bus.s_valid = 1'b1;
        bus.s_first = first;
        bus.s_data  = DATA_W'(data);
        for (int i = 0; i < 50 && !took; i++) begin
            @(negedge clk);
            took = bus.s_ready;
            @(posedge clk); #1;
        end
        chk("beat_accepted", int'(took), 1);
        bus.s_valid = 1'b0;
        bus.s_first = 1'b0;
    endtask

    task automatic send_pixel(input int r, input int g, input int b);
        send_beat(1'b1, r);
        send_beat(1'b0, g);
        send_beat(1'b0, b);
    endtask

    task automatic check_out(input string name, input int y, input int cb, input int cr);
        @(negedge clk);
        chk({name, "_valid"}, int'(bus.m_valid), 1);
        chk({name, "_y"},     int'(bus.m_y),     y);
        chk({name, "_cb"},    int'(bus.m_cb),    cb);
        chk({name, "_cr"},    int'(bus.m_cr),    cr);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_first = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b1;
        @(negedge clk);
        chk("reset_s_ready", int'(bus.s_ready), 1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_m_valid", int'(bus.m_valid), 0);
        chk("reset_phase",   int'(phase_o), 0);
        chk("reset_m_y",     int'(bus.m_y), 0);
        @(posedge clk); #1;

        send_pixel(255, 255, 255);
        check_out("white", 255, 128, 128);
        send_pixel(255, 0, 0);
        check_out("red", 77, 85, RED_CR);
        send_pixel(0, 0, 255);
        check_out("blue", 29, BLUE_CB, 107);

        // Backpressure: pixel pending with downstream stalled
        bus.m_ready = 1'b0;
        send_pixel(255, 0, 0);
        bus.s_valid = 1'b1;
        bus.s_first = 1'b1;
        bus.s_data  = DATA_W'(9);
        repeat (4) begin
            @(negedge clk);
            chk("bp_s_ready", int'(bus.s_ready), 0);
            chk("bp_m_valid", int'(bus.m_valid), 1);
            chk("bp_m_y",     int'(bus.m_y), 77);
            chk("bp_m_cb",    int'(bus.m_cb), 85);
            chk("bp_phase",   int'(phase_o), 0);
        end
        @(posedge clk); #1;
        bus.m_ready = 1'b1;
        send_beat(1'b1, 9);
        @(negedge clk);
        chk("bp_release_phase", int'(phase_o), 1);
        @(posedge clk); #1;
        send_beat(1'b0, 9);
        send_beat(1'b0, 9);
        check_out("bp_gray", 9, 128, 128);

        // Resynchronisation on an early s_first
        send_beat(1'b1, 10);
        send_beat(1'b0, 20);
        send_beat(1'b1, 255);
        @(negedge clk);
        chk("resync_err",   int'(sync_err_o), 1);
        chk("resync_phase", int'(phase_o), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("resync_err_clear", int'(sync_err_o), 0);
        @(posedge clk); #1;
        send_beat(1'b0, 255);
        send_beat(1'b0, 255);
        check_out("resync_white", 255, 128, 128);

        // Reset in the middle of a pixel
        send_beat(1'b1, 100);
        send_beat(1'b0, 50);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_phase", int'(phase_o), 0);
        @(posedge clk); #1;
        send_beat(1'b0, 0);
        send_beat(1'b0, 0);
        send_beat(1'b0, 0);
        check_out("rstmid_black", 0, 128, 128);

        // Randomized traffic, occasional misplaced s_first and rare resets
        for (int i = 0; i < 600; i++) begin
            rst         = ($urandom_range(0, 199) == 0);
            bus.s_valid = ($urandom_range(0, 9) < 7);
            bus.s_first = (cnt == 0) ^ ($urandom_range(0, 9) == 0);
            bus.s_data  = DATA_W'($urandom_range(0, MAXV));
            bus.m_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rgb_to_ycbcr_mac.md
RGB_TO_YCBCR_MAC -- requirements
Module: rgb_to_ycbcr_mac

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving component width of input and output samples (legal 8..12).
REQ-002 SHALL have parameter FRAC_W, fixed 8, giving coefficient fraction bits; coefficients are Q1.8 constants.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port s_valid  input  1  input beat valid.
REQ-006 SHALL have port s_ready  output  1  input beat accepted when s_valid && s_ready.
REQ-007 SHALL have port s_first  input  1  marks the beat as R component (start of pixel).
REQ-008 SHALL have port s_data  input  DATA_W  unsigned component, serial order R, G, B.
REQ-009 SHALL have port m_valid  output  1  output pixel valid.
REQ-010 SHALL have port m_ready  input  1  downstream accepts pixel when m_valid && m_ready.
REQ-011 SHALL have ports m_y, m_cb, m_cr  output  DATA_W each  converted unsigned components.
REQ-012 SHALL have port phase_o  output  2  current component phase (0=R, 1=G, 2=B).
REQ-013 SHALL have port sync_err_o  output  1  one-cycle pulse on pixel resynchronisation.

Function
REQ-014 SHALL use coefficients Y {77,150,29}, Cb {-43,-85,128}, Cr {128,-107,-21} for phases {0,1,2}.
REQ-015 SHALL hold three signed accumulators of width DATA_W+10; phase-0 beat loads data*coef, phases 1-2 add data*coef.
REQ-016 SHALL assert s_ready = !m_valid || m_ready, identically for all phases.
REQ-017 SHALL advance phase 0->1->2->0 on each accepted beat only; phase unchanged on idle or stalled cycles.
REQ-018 SHALL treat an accepted beat with s_first=1 as phase 0, discarding any partial accumulation.
REQ-019 SHALL pulse sync_err_o for one cycle when an accepted s_first=1 beat arrives while phase_o != 0.
REQ-020 SHALL treat an accepted beat at phase 0 with s_first=0 as R without error.
REQ-021 SHALL on the accepted phase-2 beat compute each result as (acc_final + 128) >>> 8 (arithmetic shift, round-half-up).
REQ-022 SHALL add offset 2^(DATA_W-1) to Cb and Cr results; Y gets no offset.
REQ-023 SHALL register results into m_y/m_cb/m_cr and set m_valid the cycle after the phase-2 beat (latency 1 cycle from B beat).
REQ-024 SHALL hold m_y/m_cb/m_cr and m_valid stable while m_valid && !m_ready.
REQ-025 SHALL clear m_valid after a cycle with m_valid && m_ready unless a new phase-2 beat is accepted that same cycle, in which case the new pixel replaces it with m_valid staying 1.
REQ-026 SHALL sustain one input beat per cycle with m_ready held high (one pixel per three cycles).

Reset
REQ-027 SHALL on rst=1 set m_valid=0, m_y=m_cb=m_cr=0, phase_o=0, sync_err_o=0, accumulators=0.
REQ-028 SHALL drive s_ready=1 during and after reset (m_valid=0).
REQ-029 SHALL discard a partially accumulated pixel when rst asserts mid-pixel; next accepted beat is phase 0.

Configuration
REQ-030 SHALL with macro RGB2YCC_CLAMP_EN defined saturate each result to [0, 2^DATA_W-1].
REQ-031 SHALL without RGB2YCC_CLAMP_EN output the low DATA_W bits of each result (wrap-around).

Verification
REQ-032 SHALL verify white: beats 255,255,255 (s_first on R), DATA_W=8 -> m_y=255, m_cb=128, m_cr=128 one cycle after B beat.
REQ-033 SHALL verify red: 255,0,0 -> m_y=77, m_cb=85, m_cr=255 with RGB2YCC_CLAMP_EN; m_cr=0 without.
REQ-034 SHALL verify blue: 0,0,255 -> m_y=29, m_cb=255 (clamp) / 0 (no clamp), m_cr=107.
REQ-035 SHALL verify backpressure: m_ready=0 with pixel pending -> s_ready=0, outputs stable, phase_o frozen; m_ready=1 releases next beat.
REQ-036 SHALL verify resync: R=10, G=20, then s_first=1 beat 255 -> sync_err_o pulses one cycle, followed by G=255, B=255 -> white result.
REQ-037 SHALL verify reset mid-pixel: R,G accepted, rst pulse, then 0,0,0 -> m_y=0, m_cb=128, m_cr=128, no sync_err_o.
